// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : mem_port_arbiter
// Summary : N-requester valid/ready arbiter sharing one pipelined, in-order
//           memory port, with ID tracking to route responses back.
// Rev     : 1.0  initial release
// ============================================================================
module mem_port_arbiter #(
  parameter int NPORTS    = 2,
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 64,
  parameter int MAX_OUTST = 4,
  parameter int PRIO_MODE = 0
) (
  input  logic                         clk_i,
  input  logic                         reset_i,
  input  logic [NPORTS-1:0]            req_valid_i,
  output logic [NPORTS-1:0]            req_ready_o,
  input  logic [NPORTS-1:0]            req_we_i,
  input  logic [NPORTS*ADDR_W-1:0]     req_addr_i,
  input  logic [NPORTS*DATA_W-1:0]     req_wdata_i,
  input  logic [NPORTS*DATA_W/8-1:0]   req_wmask_i,
  output logic [NPORTS-1:0]            rsp_valid_o,
  output logic [DATA_W-1:0]            rsp_rdata_o,
  output logic                         mem_req_valid_o,
  input  logic                         mem_req_ready_i,
  output logic                         mem_we_o,
  output logic [ADDR_W-1:0]            mem_addr_o,
  output logic [DATA_W-1:0]            mem_wdata_o,
  output logic [DATA_W/8-1:0]          mem_wmask_o,
  input  logic                         mem_rsp_valid_i,
  input  logic [DATA_W-1:0]            mem_rsp_rdata_i,
  output logic [$clog2(MAX_OUTST):0]   outstanding_o,
  output logic                         err_o
);
  localparam int c_MASK_W = DATA_W / 8;
  localparam int c_IDX_W  = $clog2(NPORTS);
  localparam int c_PTR_W  = $clog2(MAX_OUTST);
  localparam int c_CNT_W  = c_PTR_W + 1;
  localparam logic [c_IDX_W-1:0] c_LAST_PORT  = c_IDX_W'(NPORTS - 1);
  localparam logic [c_IDX_W:0]   c_NPORTS_EXT = (c_IDX_W + 1)'(NPORTS);
  localparam logic [c_CNT_W-1:0] c_FULL_CNT   = c_CNT_W'(MAX_OUTST);
  localparam logic [NPORTS-1:0]  c_PORT0      = NPORTS'(1);

  logic [c_IDX_W-1:0] r_rrPtr;
  logic [c_IDX_W-1:0] r_idFifo [MAX_OUTST];
  logic [c_PTR_W-1:0] r_wrPtr;
  logic [c_PTR_W-1:0] r_rdPtr;
  logic [c_CNT_W-1:0] r_count;
  logic [NPORTS-1:0]  r_rspValid;
  logic [DATA_W-1:0]  r_rspData;
  logic               r_err;

  logic [c_IDX_W-1:0] w_grantIdx;
  logic               w_anyValid;
  logic               w_full;
  logic               w_push;
  logic               w_pop;

  assign w_anyValid = |req_valid_i;

  generate
    if (PRIO_MODE == 0) begin : g_roundRobin
      logic [NPORTS-1:0]  w_rot;
      logic [c_IDX_W-1:0] w_off;
      logic [c_IDX_W:0]   w_sum;

      // Rotate so bit 0 is the port at rr_ptr, find the first set bit, rotate back.
      assign w_rot = NPORTS'({req_valid_i, req_valid_i} >> r_rrPtr);

      always_comb begin
        w_off = '0;
        for (int k = NPORTS - 1; k >= 0; k--) begin
          if (w_rot[k]) w_off = c_IDX_W'(k);
        end
      end

      assign w_sum      = {1'b0, r_rrPtr} + {1'b0, w_off};
      assign w_grantIdx = (w_sum >= c_NPORTS_EXT) ? c_IDX_W'(w_sum - c_NPORTS_EXT)
                                                  : w_sum[c_IDX_W-1:0];
    end else begin : g_fixedPrio
      always_comb begin
        w_grantIdx = '0;
        for (int k = NPORTS - 1; k >= 0; k--) begin
          if (req_valid_i[k]) w_grantIdx = c_IDX_W'(k);
        end
      end
    end
  endgenerate

  // Full looks only at the registered count so ready never depends on the response path.
  assign w_full          = (r_count == c_FULL_CNT);
  assign mem_req_valid_o = reset_i & w_anyValid & ~w_full;
  assign w_push          = mem_req_valid_o & mem_req_ready_i;
  assign w_pop           = mem_rsp_valid_i & (r_count != '0);
  assign req_ready_o     = w_push ? (c_PORT0 << w_grantIdx) : '0;

  assign mem_we_o    = req_we_i[w_grantIdx];
  assign mem_addr_o  = req_addr_i[w_grantIdx*ADDR_W +: ADDR_W];
  assign mem_wdata_o = req_wdata_i[w_grantIdx*DATA_W +: DATA_W];
  assign mem_wmask_o = req_wmask_i[w_grantIdx*c_MASK_W +: c_MASK_W];

  always_ff @(posedge clk_i) begin
    if (w_push) r_idFifo[r_wrPtr] <= w_grantIdx;
  end

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      r_rrPtr    <= '0;
      r_wrPtr    <= '0;
      r_rdPtr    <= '0;
      r_count    <= '0;
      r_rspValid <= '0;
      r_rspData  <= '0;
      r_err      <= 1'b0;
    end else begin
      if (w_push) begin
        r_wrPtr <= r_wrPtr + 1'b1;
        if (PRIO_MODE == 0) r_rrPtr <= (w_grantIdx == c_LAST_PORT) ? '0 : w_grantIdx + 1'b1;
      end

      if (w_pop) begin
        r_rdPtr    <= r_rdPtr + 1'b1;
        r_rspValid <= c_PORT0 << r_idFifo[r_rdPtr];
        r_rspData  <= mem_rsp_rdata_i;
      end else begin
        r_rspValid <= '0;
      end

      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase

      if (mem_rsp_valid_i && (r_count == '0)) r_err <= 1'b1;
    end
  end

  assign rsp_valid_o   = r_rspValid;
  assign rsp_rdata_o   = r_rspData;
  assign outstanding_o = r_count;
  assign err_o         = r_err;

endmodule
`default_nettype wire

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Parametrised N-requester arbiter that shares one pipelined memory port between pipeline clients (fetch, load/store, AMO, debug, ...).
- It replaces the fixed, zero-latency IMem/DMem wiring of the current core with a valid/ready request channel and an in-order response channel.
- It tracks up to MAX_OUTST in-flight transactions and routes each response back to the requester that issued it.

Parameters:
- NPORTS, 2, number of requesters (2..8).
- ADDR_W, 32, address width.
- DATA_W, 64, data width; must be a multiple of 8.
- MAX_OUTST, 4, depth of the in-flight ID FIFO; must be a power of 2, >=2.
- PRIO_MODE, 0, arbitration mode: 0 = round-robin, 1 = fixed priority (port 0 highest).

Ports:
- clk_i  in  1  clock; all state updates on rising edge.
- reset_i  in  1  asynchronous, active-low reset.
- req_valid_i  in  NPORTS  per-port request valid.
- req_ready_o  out  NPORTS  per-port request accepted this cycle.
- req_we_i  in  NPORTS  per-port write enable (1 = write).
- req_addr_i  in  NPORTS*ADDR_W  flattened per-port addresses; port i occupies bits [i*ADDR_W +: ADDR_W].
- req_wdata_i  in  NPORTS*DATA_W  flattened write data.
- req_wmask_i  in  NPORTS*DATA_W/8  flattened byte write masks.
- rsp_valid_o  out  NPORTS  one-hot response strobe.
- rsp_rdata_o  out  DATA_W  response data, shared by all ports; qualify with rsp_valid_o.
- mem_req_valid_o  out  1  downstream request valid.
- mem_req_ready_i  in  1  downstream request accepted.
- mem_we_o  out  1  downstream write enable.
- mem_addr_o  out  ADDR_W  downstream address.
- mem_wdata_o  out  DATA_W  downstream write data.
- mem_wmask_o  out  DATA_W/8  downstream byte write mask.
- mem_rsp_valid_i  in  1  downstream response strobe (one per accepted request, in order).
- mem_rsp_rdata_i  in  DATA_W  downstream response data.
- outstanding_o  out  $clog2(MAX_OUTST)+1  in-flight transaction count.
- err_o  out  1  sticky protocol error flag.

Behaviour:
- Reset (asynchronous assert, deassert synchronised externally):
  - rr_ptr=0, FIFO empty, outstanding_o=0, rsp_valid_o=0, rsp_rdata_o=0, err_o=0.
  - All *_ready_o / *_valid_o outputs low while reset_i=0.
- Grant (combinational):
  - PRIO_MODE=0: first set req_valid_i bit scanning from rr_ptr upward, wrapping modulo NPORTS.
  - PRIO_MODE=1: lowest-index set bit.
  - At most one grant per cycle.
- Downstream request:
  - mem_req_valid_o = |req_valid_i && !full.
  - mem_* payload = fields of the granted port; payload is don't-care when mem_req_valid_o=0.
- Per-port ready:
  - req_ready_o[g] = grant[g] && mem_req_ready_i && !full; all other bits 0.
  - A handshake (req_valid_i[g] && req_ready_o[g]) pushes g into the ID FIFO.
  - Round-robin only: the handshake also sets rr_ptr <= (g+1) mod NPORTS.
  - rr_ptr is unchanged when no handshake occurs.
- full = (count == MAX_OUTST), computed from the registered count. A same-cycle pop does NOT unblock a push; this is deliberate, to keep ready off the response path.
- Every accepted request, read or write, receives exactly one mem_rsp_valid_i, in order. Write responses carry don't-care data but still strobe rsp_valid_o.
- Response, registered, 1-cycle latency:
  - On mem_rsp_valid_i with FIFO non-empty: pop id; next cycle rsp_valid_o = onehot(id) and rsp_rdata_o = mem_rsp_rdata_i.
  - Otherwise rsp_valid_o = 0 next cycle; rsp_rdata_o holds its last value.
- Spurious response (mem_rsp_valid_i with count==0): ignored, no pop, err_o <= 1 until reset.
- Counter update:
  - count increments on push only, decrements on pop only, unchanged when both occur.
  - FIFO pointers wrap modulo MAX_OUTST.
  - outstanding_o = count.
- Requesters must hold valid and payload until ready. If a requester drops valid before ready, the arbiter does not misbehave; the next grant is simply recomputed.
- Reset mid-transaction discards all in-flight IDs; responses arriving afterwards set err_o.

Test Plan:
1. NPORTS=2, RR, port0 reads 0x100 with mem_req_ready_i=1 and memory returning 0xDEAD_BEEF two cycles later -> req_ready_o=01 for 1 cycle, outstanding 1->0, rsp_valid_o=01 with rsp_rdata_o=0xDEADBEEF exactly one cycle after mem_rsp_valid_i.
2. RR, both ports hold valid for 4 handshakes -> grant sequence 0,1,0,1; responses return rsp_valid_o = 01,10,01,10 in order.
3. PRIO_MODE=1, both ports valid for 3 cycles -> port0 granted every cycle, port1 req_ready_o stays 0; port1 granted on the first cycle port0 drops valid.
4. MAX_OUTST=4, memory withholds responses, port0 streams requests -> 4 handshakes, then outstanding_o=4 and req_ready_o=0. A single response with a same-cycle new request gives no handshake that cycle; the request is accepted the next cycle.
5. mem_rsp_valid_i pulsed with outstanding_o=0 -> rsp_valid_o stays 0, err_o=1 and remains 1 until reset_i low.
6. reset_i driven low with 3 outstanding -> outputs clear immediately (asynchronously). After release, a late mem_rsp_valid_i sets err_o and no rsp_valid_o fires.
